// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, mux/ALU
// encodings, state codes and the per-state control word.
package mips_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // pc_write, ir_write and done are qualified by mem_ready in states that
    // also raise mem_req; the top applies that gating.
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_write;
        logic       mem_req;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       branch;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_state_decoder.sv
// Purely combinational state -> control word decode for the multicycle
// controller. Unused state codes decode to an all-zero word.
module mips_mc_state_decoder
    import mips_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.done       = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dest  = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_ALUOUT;
                ctrl.branch    = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PC_JUMP;
                ctrl.pc_write = 1'b1;
                ctrl.done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath.
// Optional MIPS_MC_BNE_EN adds bne decode through the BRANCH state.
module mips_multicycle_controller
    import mips_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic           pc_write,
    output logic           ir_write,
    output logic           iord,
    output logic           mem_write,
    output logic           mem_req,
    output logic           reg_write,
    output logic           reg_dest,
    output logic           mem_to_reg,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_src,
    output logic           branch,
    output logic           instr_done,
    output logic           illegal_op,
    output logic [STW-1:0] state_dbg
);

    state_t state;
    state_t decode_next;
    ctrl_t  cw;
    logic   op_legal;
    logic   mem_done;
    logic   take_branch;

    mips_mc_state_decoder u_dec (
        .state (state),
        .ctrl  (cw)
    );

    always_comb begin
        decode_next = S_FETCH;
        op_legal    = 1'b1;
        case (opcode)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_RTYPE:     decode_next = S_EXECUTE;
            OP_ADDI:      decode_next = S_ADDIEX;
            OP_BEQ:       decode_next = S_BRANCH;
            OP_J:         decode_next = S_JUMP;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       decode_next = S_BRANCH;
`endif
            default:      op_legal    = 1'b0;
        endcase
    end

`ifdef MIPS_MC_BNE_EN
    logic bne_q;
    assign take_branch = bne_q ? ~zero : zero;
`else
    assign take_branch = zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
`ifdef MIPS_MC_BNE_EN
            bne_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE:   state <= decode_next;
                S_MEMADR:   state <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECUTE:  state <= S_ALUWB;
                S_ADDIEX:   state <= S_ADDIWB;
                default:    state <= S_FETCH;
            endcase
`ifdef MIPS_MC_BNE_EN
            if (state == S_FETCH)
                bne_q <= 1'b0;
            else if (state == S_DECODE)
                bne_q <= (opcode == OP_BNE);
`endif
        end
    end

    // Strobes that complete a memory access wait for mem_ready.
    assign mem_done   = mem_ready | ~cw.mem_req;

    assign pc_write   = rst_n & cw.pc_write & mem_done;
    assign ir_write   = rst_n & cw.ir_write & mem_done;
    assign pc_en      = pc_write | (rst_n & cw.branch & take_branch);
    assign mem_write  = rst_n & cw.mem_write;
    assign reg_write  = rst_n & cw.reg_write;
    assign illegal_op = rst_n & (state == S_DECODE) & ~op_legal;
    assign instr_done = rst_n & ((cw.done & mem_done) | illegal_op);

    assign iord       = cw.iord;
    assign mem_req    = cw.mem_req;
    assign reg_dest   = cw.reg_dest;
    assign mem_to_reg = cw.mem_to_reg;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign alu_op     = cw.alu_op;
    assign pc_src     = cw.pc_src;
    assign branch     = cw.branch;
    assign state_dbg  = STW'(state);

endmodule
